interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Sits directly upstream of the multi-cycle control unit and drives its INT_control / NMI_control inputs.
//  Detects edges on NUM_IRQ maskable lines and one non-maskable line, latches them as pending and selects one by fixed priority.
//  Issues one request at a time and holds it until the control unit acknowledges entry into its INT or NMI service state.
//  Tracks the in-service level until software signals end-of-interrupt, so the service routine is not re-entered.
// PARAMETERS
//  NUM_IRQ    4   number of maskable interrupt lines (1..8); irq[0] has the highest priority
//  ID_W       3   width of int_id; must satisfy 2**ID_W >= NUM_IRQ
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         synchronous active-high reset
//  irq          in   NUM_IRQ   maskable request lines, level in, rising edge significant
//  nmi_in       in   1         non-maskable request line, rising edge significant
//  mask_we      in   1         write strobe for the mask register
//  mask_wdata   in   NUM_IRQ   new mask; bit=1 blocks that line
//  gie          in   1         global maskable-interrupt enable
//  int_ack      in   1         one-cycle pulse: control unit has entered its INT service state
//  nmi_ack      in   1         one-cycle pulse: control unit has entered its NMI service state
//  eoi          in   1         one-cycle pulse: end of current service routine
//  INT_control  out  1         maskable request to the control unit
//  NMI_control  out  1         non-maskable request to the control unit
//  int_id       out  ID_W      index of the line being requested or serviced
//  pending      out  NUM_IRQ   pending-flag register, readable by software
//  mask         out  NUM_IRQ   current mask register
// BEHAVIOUR
//  Reset: state=IDLE; pending=0; mask=all 1s (every line blocked); INT_control=0; NMI_control=0; int_id=0.
//   Edge-detect history registers are loaded with the current irq/nmi_in, so lines already high at reset do not fire.
//   Reset asserted mid-request or mid-service aborts it and returns to IDLE with the values above.
//  Edge detect: irq_q <= irq every cycle. rise = irq & ~irq_q sets the pending bit on the next edge.
//   nmi_in is handled the same way and sets nmi_pend.
//  Pending clear: int_ack clears pending[int_id]. If a new rise on the same line arrives in the same cycle, set wins.
//   nmi_ack clears nmi_pend, with the same set-wins rule.
//  Mask: mask_we loads mask_wdata on the next edge. Masking never clears pending bits; it only blocks selection.
//  Eligible lines: elig = pending & ~mask, and only while gie=1. Winner = lowest set index of elig.
//  FSM states: IDLE, INT_REQ, INT_SVC, NMI_REQ, NMI_SVC.
//   IDLE: if nmi_pend -> NMI_REQ. Else if elig!=0 -> INT_REQ and latch int_id=winner. NMI always beats maskable.
//   INT_REQ: INT_control=1 and int_id is frozen.
//    int_ack -> INT_SVC.
//    nmi_pend rises before the ack -> drop INT_control and go to NMI_REQ; pending[int_id] is kept.
//    The target bit becomes masked, gie drops or the bit clears before the ack -> back to IDLE.
//   INT_SVC: INT_control=0. eoi -> IDLE. nmi_pend -> NMI_REQ, which nests the NMI.
//    No new maskable request is issued until eoi.
//   NMI_REQ: NMI_control=1 until nmi_ack -> NMI_SVC.
//   NMI_SVC: NMI_control=0; eoi -> IDLE. A further NMI edge while here stays pending until that eoi.
//   Nesting is one level only. An eoi in NMI_SVC entered from INT_SVC also returns to IDLE.
//   eoi or ack in a state that does not expect it is ignored.
//  Latency: rise at edge N -> pending at N+1 -> FSM enters REQ at N+2 and asserts the request then (registered output).
//  Outputs are registered Moore outputs with no combinational path from input to output.
//  Request lines are held steadily until acknowledged, so the control unit may sample them in any state.
// TESTING
//  1. Reset, then mask_we with mask=0 and gie=1; pulse irq[2] -> INT_control=1 two cycles later with int_id=2.
//     Then int_ack -> INT_control=0 and pending[2]=0.
//  2. Rise irq[3] and irq[1] in the same cycle -> int_id=1 first. After ack and eoi -> int_id=3 requested.
//  3. mask=4'b0100, pulse irq[2] -> pending[2]=1 and no request. Write mask=0 -> request with int_id=2.
//  4. While in INT_REQ with int_id=0, pulse nmi_in -> INT_control=0, NMI_control=1 and pending[0] kept.
//     After nmi_ack and eoi -> INT_control=1 with int_id=0 again.
//  5. Hold irq[0]=1 through reset -> no request. Then drop irq[0] and raise it again -> request.
//  6. Assert rst during INT_SVC -> all outputs are at reset values in the next cycle, and a following eoi has no effect.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Edge-detects NUM_IRQ maskable lines and one NMI line, keeps them pending,
//   and presents one request at a time to the multi-cycle control unit using
//   fixed priority (NMI first, then lowest irq index). It tracks the
//   in-service level until eoi so that a routine is not re-entered.
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   irq, nmi_in           request lines; only rising edges are significant
//   mask_we, mask_wdata   mask register write (bit=1 blocks the line)
//   gie                   global enable for maskable lines
//   int_ack, nmi_ack      control unit entered its INT / NMI service state
//   eoi                   end of the current service routine
//   INT_control           registered maskable request
//   NMI_control           registered non-maskable request
//   int_id                line being requested or serviced
//   pending, mask         software-visible pending flags and mask
module interrupt_controller #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               gie,
  input  logic               int_ack,
  input  logic               nmi_ack,
  input  logic               eoi,
  output logic               INT_control,
  output logic               NMI_control,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INT_REQ = 3'd1,
    S_INT_SVC = 3'd2,
    S_NMI_REQ = 3'd3,
    S_NMI_SVC = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic               nmi_q;
  logic               nmi_pend;
  logic [NUM_IRQ-1:0] irq_rise;
  logic               nmi_rise;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic               any_elig;
  logic               tgt_ok;
  logic               int_fire;
  logic               nmi_fire;
  logic               int_ctrl_d;
  logic               nmi_ctrl_d;
  logic [ID_W-1:0]    int_id_d;

  assign irq_rise = irq & ~irq_q;
  assign nmi_rise = nmi_in & ~nmi_q;
  assign elig     = gie ? (pending & ~mask) : '0;
  assign any_elig = |elig;
  // Acks only count in the state that is waiting for them.
  assign int_fire = (state_q == S_INT_REQ) && int_ack;
  assign nmi_fire = (state_q == S_NMI_REQ) && nmi_ack;

  // Lowest-index eligible line wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // Decode int_id into the target line's eligibility and its ack clear.
  always_comb begin
    tgt_ok  = 1'b0;
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int_id == ID_W'(i)) begin
        tgt_ok     = elig[i];
        ack_clr[i] = int_fire;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an ack wins over a same-cycle NMI, eoi over a nesting NMI.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (nmi_pend)      state_d = S_NMI_REQ;
        else if (any_elig) state_d = S_INT_REQ;
      end
      S_INT_REQ: begin
        if (int_ack)       state_d = S_INT_SVC;
        else if (nmi_pend) state_d = S_NMI_REQ;
        else if (!tgt_ok)  state_d = S_IDLE;
      end
      S_INT_SVC: begin
        if (eoi)           state_d = S_IDLE;
        else if (nmi_pend) state_d = S_NMI_REQ;
      end
      S_NMI_REQ: begin
        if (nmi_ack)       state_d = S_NMI_SVC;
      end
      S_NMI_SVC: begin
        if (eoi)           state_d = S_IDLE;
      end
      default:             state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state.
  always_comb begin
    int_ctrl_d = (state_d == S_INT_REQ);
    nmi_ctrl_d = (state_d == S_NMI_REQ);
    int_id_d   = int_id;
    if ((state_q == S_IDLE) && (state_d == S_INT_REQ)) int_id_d = winner;
  end

  // Datapath and output registers; a new rise wins over a same-cycle ack clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q       <= irq;
      nmi_q       <= nmi_in;
      pending     <= '0;
      nmi_pend    <= 1'b0;
      mask        <= '1;
      INT_control <= 1'b0;
      NMI_control <= 1'b0;
      int_id      <= '0;
    end else begin
      irq_q       <= irq;
      nmi_q       <= nmi_in;
      pending     <= (pending & ~ack_clr) | irq_rise;
      nmi_pend    <= (nmi_pend & ~nmi_fire) | nmi_rise;
      if (mask_we) mask <= mask_wdata;
      INT_control <= int_ctrl_d;
      NMI_control <= nmi_ctrl_d;
      int_id      <= int_id_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 3;

  // model modes
  localparam int M_IDLE = 0, M_IREQ = 1, M_ISVC = 2, M_NREQ = 3, M_NSVC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          nmi_in, mask_we, gie, int_ack, nmi_ack, eoi;
  logic [N-1:0]  mask_wdata;
  logic          INT_control, NMI_control;
  logic [IW-1:0] int_id;
  logic [N-1:0]  pending, mask;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  int m_mode;
  int m_id;
  bit m_pend [N];
  bit m_mask [N];
  bit m_prev [N];
  bit m_nmi_pend, m_prev_nmi;

  interrupt_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .irq(irq), .nmi_in(nmi_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .gie(gie),
    .int_ack(int_ack), .nmi_ack(nmi_ack), .eoi(eoi),
    .INT_control(INT_control), .NMI_control(NMI_control),
    .int_id(int_id), .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  // One clock of the behavioural model, using the inputs seen at this edge.
  task automatic model_step();
    int win;
    int nm;
    bit ok;
    if (rst) begin
      m_mode = M_IDLE; m_id = 0; m_nmi_pend = 0; m_prev_nmi = nmi_in;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 1; m_prev[i] = irq[i];
      end
      return;
    end
    win = -1;
    for (int i = N - 1; i >= 0; i--)
      if (gie && m_pend[i] && !m_mask[i]) win = i;
    ok = gie && m_pend[m_id] && !m_mask[m_id];
    nm = m_mode;
    case (m_mode)
      M_IDLE: if (m_nmi_pend) nm = M_NREQ; else if (win >= 0) nm = M_IREQ;
      M_IREQ: if (int_ack) nm = M_ISVC; else if (m_nmi_pend) nm = M_NREQ; else if (!ok) nm = M_IDLE;
      M_ISVC: if (eoi) nm = M_IDLE; else if (m_nmi_pend) nm = M_NREQ;
      M_NREQ: if (nmi_ack) nm = M_NSVC;
      M_NSVC: if (eoi) nm = M_IDLE;
      default: nm = M_IDLE;
    endcase
    for (int i = 0; i < N; i++) begin
      bit cleared;
      cleared = (m_mode == M_IREQ) && int_ack && (m_id == i);
      m_pend[i] = (irq[i] && !m_prev[i]) || (m_pend[i] && !cleared);
      m_prev[i] = irq[i];
      if (mask_we) m_mask[i] = mask_wdata[i];
    end
    m_nmi_pend = (nmi_in && !m_prev_nmi) || (m_nmi_pend && !((m_mode == M_NREQ) && nmi_ack));
    m_prev_nmi = nmi_in;
    if (m_mode == M_IDLE && nm == M_IREQ) m_id = win;
    m_mode = nm;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_ack();
    int_ack = 1; tick(); int_ack = 0;
  endtask

  task automatic pulse_eoi();
    eoi = 1; tick(); eoi = 0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1; mask_wdata = m; tick(); mask_we = 0;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    rst = 1; tick(); tick(); rst = 0;
    exp = {1'b0, 1'b0, 3'd0, 4'h0, 4'hF};
    tests_run++;
    if ({INT_control, NMI_control, int_id, pending, mask} !== exp) begin
      tests_failed++;
      $display("FAIL reset: got %b want %b", {INT_control, NMI_control, int_id, pending, mask}, exp);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp;
    gie = 1;
    write_mask(4'h0);
    irq = 4'b0100; tick(); irq = 4'b0000;
    tests_run++;
    if ({INT_control, pending} !== {1'b0, 4'b0100}) begin
      tests_failed++;
      $display("FAIL basic_pend: got %b want %b", {INT_control, pending}, {1'b0, 4'b0100});
    end
    tick();
    exp = {1'b1, 1'b0, 3'd2};
    tests_run++;
    if ({INT_control, NMI_control, int_id} !== exp) begin
      tests_failed++;
      $display("FAIL basic_req: got %b want %b", {INT_control, NMI_control, int_id}, exp);
    end
    pulse_ack();
    tests_run++;
    if ({INT_control, int_id, pending} !== {1'b0, 3'd2, 4'b0000}) begin
      tests_failed++;
      $display("FAIL basic_ack: got %b want %b", {INT_control, int_id, pending}, {1'b0, 3'd2, 4'b0000});
    end
    pulse_eoi();
  endtask

  task automatic test_priority();
    irq = 4'b1010; tick(); irq = 4'b0000; tick();
    tests_run++;
    if ({INT_control, int_id, pending} !== {1'b1, 3'd1, 4'b1010}) begin
      tests_failed++;
      $display("FAIL prio_first: got %b want %b", {INT_control, int_id, pending}, {1'b1, 3'd1, 4'b1010});
    end
    pulse_ack();
    tick();
    tests_run++;
    if (INT_control !== 1'b0) begin
      tests_failed++;
      $display("FAIL prio_svc_block: got %b want 0", INT_control);
    end
    pulse_eoi();
    tick();
    tests_run++;
    if ({INT_control, int_id} !== {1'b1, 3'd3}) begin
      tests_failed++;
      $display("FAIL prio_second: got %b want %b", {INT_control, int_id}, {1'b1, 3'd3});
    end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_mask();
    write_mask(4'b0100);
    irq = 4'b0100; tick(); irq = 4'b0000; tick(); tick();
    tests_run++;
    if ({INT_control, pending} !== {1'b0, 4'b0100}) begin
      tests_failed++;
      $display("FAIL mask_block: got %b want %b", {INT_control, pending}, {1'b0, 4'b0100});
    end
    write_mask(4'b0000);
    tick();
    tests_run++;
    if ({INT_control, int_id} !== {1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL mask_release: got %b want %b", {INT_control, int_id}, {1'b1, 3'd2});
    end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_nmi_preempt();
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    nmi_in = 1; tick(); nmi_in = 0; tick();
    tests_run++;
    if ({INT_control, NMI_control, pending} !== {1'b0, 1'b1, 4'b0001}) begin
      tests_failed++;
      $display("FAIL nmi_preempt: got %b want %b", {INT_control, NMI_control, pending}, {1'b0, 1'b1, 4'b0001});
    end
    nmi_ack = 1; tick(); nmi_ack = 0;
    tests_run++;
    if ({INT_control, NMI_control} !== 2'b00) begin
      tests_failed++;
      $display("FAIL nmi_svc: got %b want 00", {INT_control, NMI_control});
    end
    pulse_eoi();
    tick();
    tests_run++;
    if ({INT_control, NMI_control, int_id} !== {1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL nmi_resume: got %b want %b", {INT_control, NMI_control, int_id}, {1'b1, 1'b0, 3'd0});
    end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_level_at_reset();
    irq = 4'b0001;
    rst = 1; tick(); tick(); rst = 0;
    write_mask(4'h0);
    tick(); tick();
    tests_run++;
    if ({INT_control, pending} !== {1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL held_at_reset: got %b want %b", {INT_control, pending}, {1'b0, 4'b0000});
    end
    irq = 4'b0000; tick();
    irq = 4'b0001; tick(); tick();
    tests_run++;
    if ({INT_control, int_id} !== {1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL reedge: got %b want %b", {INT_control, int_id}, {1'b1, 3'd0});
    end
    pulse_ack(); pulse_eoi();
    irq = 4'b0000; tick();
  endtask

  task automatic test_reset_in_service();
    logic [12:0] exp;
    irq = 4'b0010; tick(); irq = 4'b0000; tick();
    pulse_ack();
    irq = 4'b1000; tick(); irq = 4'b0000;
    rst = 1; tick(); rst = 0;
    exp = {1'b0, 1'b0, 3'd0, 4'h0, 4'hF};
    tests_run++;
    if ({INT_control, NMI_control, int_id, pending, mask} !== exp) begin
      tests_failed++;
      $display("FAIL rst_abort: got %b want %b", {INT_control, NMI_control, int_id, pending, mask}, exp);
    end
    pulse_eoi(); tick();
    tests_run++;
    if ({INT_control, NMI_control, int_id, pending, mask} !== exp) begin
      tests_failed++;
      $display("FAIL rst_eoi_ignored: got %b want %b", {INT_control, NMI_control, int_id, pending, mask}, exp);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp, got;
    logic [N-1:0] pv, mv;
    write_mask(4'h0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
      if ($urandom_range(0, 39) == 0) nmi_in = ~nmi_in;
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wdata = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      gie = ($urandom_range(0, 19) != 0);
      int_ack = ((m_mode == M_IREQ) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
      nmi_ack = ((m_mode == M_NREQ) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
      eoi = ($urandom_range(0, 5) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        pv[i] = m_pend[i];
        mv[i] = m_mask[i];
      end
      exp = {m_mode == M_IREQ, m_mode == M_NREQ, IW'(m_id), pv, mv};
      got = {INT_control, NMI_control, int_id, pending, mask};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random cycle %0d: got %b want %b", c, got, exp);
      end
    end
    rst = 0; mask_we = 0; int_ack = 0; nmi_ack = 0; eoi = 0;
  endtask

  initial begin
    rst = 1; irq = '0; nmi_in = 0; mask_we = 0; mask_wdata = '0;
    gie = 1; int_ack = 0; nmi_ack = 0; eoi = 0;
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_nmi_preempt();
    test_level_at_reset();
    test_reset_in_service();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
